// File: rtl/data_mem_responder.sv
// Wait-state data memory for the MEM stage: holds each access for LATENCY
// cycles, commits on the edge entering DONE, and stalls the pipeline meanwhile.
module data_mem_responder #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int unsigned AW = $clog2(SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [SIZE];

    logic          req_we;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_err;
    logic [AW-1:0] req_idx;
    logic          commit;
    logic          wr_en;

    // With LATENCY=0 the commit edge is also the capture edge, so the
    // live inputs stand in for the not-yet-loaded request registers.
    always_comb begin
        if (state_q == S_IDLE) begin
            req_we    = we_i;
            req_addr  = addr_i;
            req_wdata = data_i;
        end else begin
            req_we    = we_q;
            req_addr  = addr_q;
            req_wdata = wdata_q;
        end
        req_err = (|req_addr[1:0]) | (|req_addr[31:AW+2]);
        req_idx = req_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cs_i) begin
                    state_d = (LATENCY == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == S_IDLE && cs_i) begin
            cnt_d   = 4'(LATENCY);
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = data_i;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_comb begin
        commit  = (state_d == S_DONE);
        wr_en   = commit & req_we & ~req_err;
        ready_d = commit;
        err_d   = commit & req_err;
        rdata_d = rdata_q;
        if (commit && !req_we) begin
            rdata_d = req_err ? 32'd0 : mem_q[req_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[req_idx] <= req_wdata;
        end
    end

    assign data_o  = rdata_q;
    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign stall_o = cs_i & ~ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: LATENCY=2 and LATENCY=0 instances
// checked against an abstract word-array model of the memory.
module tb_data_mem_responder;

    localparam int SIZE  = 32;
    localparam int LAT_A = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_a, we_a, cs_b, we_b;
    logic [31:0] addr_a, data_a, addr_b, data_b;
    logic [31:0] dout_a, dout_b;
    logic        ready_a, err_a, stall_a;
    logic        ready_b, err_b, stall_b;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] m_mem [2][SIZE];
    logic [31:0] m_rd  [2];

    always #5 clk = ~clk;

    data_mem_responder #(.SIZE(SIZE), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst), .cs_i(cs_a), .we_i(we_a),
        .addr_i(addr_a), .data_i(data_a), .data_o(dout_a),
        .ready_o(ready_a), .err_o(err_a), .stall_o(stall_a)
    );

    data_mem_responder #(.SIZE(SIZE), .LATENCY(0)) u_dut_b (
        .clk(clk), .rst(rst), .cs_i(cs_b), .we_i(we_b),
        .addr_i(addr_b), .data_i(data_b), .data_o(dout_b),
        .ready_o(ready_b), .err_o(err_b), .stall_o(stall_b)
    );

    function automatic logic m_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * SIZE);
    endfunction

    function automatic int exp_lat(input int sel);
        return (sel == 0) ? LAT_A + 1 : 1;
    endfunction

    task automatic m_apply(input int sel, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (m_err(a)) begin
            if (!we) m_rd[sel] = 32'd0;
        end else if (we) begin
            m_mem[sel][a / 4] = d;
        end else begin
            m_rd[sel] = m_mem[sel][a / 4];
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < 2; s++) begin
            m_rd[s] = 32'd0;
            for (int i = 0; i < SIZE; i++) m_mem[s][i] = 32'd0;
        end
    endtask

    task automatic drive(input int sel, input logic cs, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            cs_a = cs; we_a = we; addr_a = a; data_a = d;
        end else begin
            cs_b = cs; we_b = we; addr_b = a; data_b = d;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        m_clear();
    endtask

    // Runs one access starting now (posedge+1); inputs switch to a2/d2
    // after the capture edge. Returns at posedge+1 of the following IDLE cycle.
    task automatic access(input int sel, input logic we,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] a2, input logic [31:0] d2,
                          input logic keep, output int lat, output logic err,
                          output logic [31:0] rd, output int stall_bad);
        logic rdy, stl;
        lat = -1; err = 1'b0; rd = 32'd0; stall_bad = 0;
        drive(sel, 1'b1, we, a, d);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            rdy = (sel == 0) ? ready_a : ready_b;
            stl = (sel == 0) ? stall_a : stall_b;
            if (rdy === 1'b1) begin
                lat = k;
                err = (sel == 0) ? err_a : err_b;
                rd  = (sel == 0) ? dout_a : dout_b;
                if (stl !== 1'b0) stall_bad++;
                break;
            end
            if (stl !== 1'b1) stall_bad++;
            @(posedge clk); #1;
            if (k == 0) drive(sel, 1'b1, we, a2, d2);
        end
        @(posedge clk); #1;
        if (!keep) drive(sel, 1'b0, 1'b0, $urandom, $urandom);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int r;
        r = $urandom_range(0, 9);
        a = $urandom_range(0, SIZE - 1) * 4;
        if (r == 0) a = a + $urandom_range(1, 3);
        if (r == 1) a = 4 * SIZE + $urandom_range(0, 1000) * 4;
        if (r == 2) a = $urandom;
        return a;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ready_a !== 1'b0 || err_a !== 1'b0 || dout_a !== 32'd0) begin
            n_errs++;
            $display("FAIL reset_out got rdy=%b err=%b d=%h exp 0/0/0",
                     ready_a, err_a, dout_a);
        end
        cs_a = 1'b1; #1;
        n_checks++;
        if (stall_a !== 1'b1) begin
            n_errs++;
            $display("FAIL reset_stall_hi got=%b exp=1", stall_a);
        end
        cs_a = 1'b0; #1;
        n_checks++;
        if (stall_a !== 1'b0) begin
            n_errs++;
            $display("FAIL reset_stall_lo got=%b exp=0", stall_a);
        end
        @(posedge clk); #1 rst = 1'b0;
        m_clear();
    endtask

    task automatic test_reset_load();
        int lat, sb; logic err; logic [31:0] rd;
        access(0, 1'b0, 32'h8, 32'h0, 32'h8, 32'h0, 1'b0, lat, err, rd, sb);
        m_apply(0, 1'b0, 32'h8, 32'h0);
        n_checks++;
        if (lat !== 3 || sb !== 0) begin
            n_errs++;
            $display("FAIL first_load_timing got lat=%0d stall_bad=%0d exp 3/0", lat, sb);
        end
        n_checks++;
        if (rd !== 32'd0 || err !== 1'b0) begin
            n_errs++;
            $display("FAIL first_load_data got d=%h err=%b exp 0/0", rd, err);
        end
    endtask

    task automatic test_store_load();
        int l1, l2, sb1, sb2; logic e1, e2; logic [31:0] r1, r2;
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF,
               1'b1, l1, e1, r1, sb1);
        m_apply(0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, 1'b0, l2, e2, r2, sb2);
        m_apply(0, 1'b0, 32'h10, 32'h0);
        n_checks++;
        if ((l1 + 1) + (l2 + 1) !== 8 || sb1 + sb2 !== 0) begin
            n_errs++;
            $display("FAIL pair_cycles got=%0d stall_bad=%0d exp 8/0",
                     l1 + l2 + 2, sb1 + sb2);
        end
        n_checks++;
        if (r2 !== 32'hDEADBEEF || e2 !== 1'b0) begin
            n_errs++;
            $display("FAIL raw_data got=%h err=%b exp=deadbeef/0", r2, e2);
        end
    endtask

    task automatic test_errors();
        int lat, sb; logic err; logic [31:0] rd;
        access(0, 1'b1, 32'h12, 32'h1, 32'h12, 32'h1, 1'b0, lat, err, rd, sb);
        m_apply(0, 1'b1, 32'h12, 32'h1);
        n_checks++;
        if (err !== 1'b1 || lat !== 3) begin
            n_errs++;
            $display("FAIL misalign_err got err=%b lat=%0d exp 1/3", err, lat);
        end
        access(0, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, 1'b0, lat, err, rd, sb);
        m_apply(0, 1'b0, 32'h10, 32'h0);
        n_checks++;
        if (rd !== m_rd[0] || err !== 1'b0) begin
            n_errs++;
            $display("FAIL misalign_nowrite got=%h exp=%h", rd, m_rd[0]);
        end
        access(0, 1'b0, 32'h80, 32'h0, 32'h80, 32'h0, 1'b0, lat, err, rd, sb);
        m_apply(0, 1'b0, 32'h80, 32'h0);
        n_checks++;
        if (err !== 1'b1 || rd !== 32'd0) begin
            n_errs++;
            $display("FAIL range_err got err=%b d=%h exp 1/0", err, rd);
        end
    endtask

    task automatic test_capture();
        int lat, sb; logic err; logic [31:0] rd, junk;
        junk = $urandom;
        access(0, 1'b1, 32'h4, 32'hA5A5A5A5, 32'h8, junk, 1'b0, lat, err, rd, sb);
        m_apply(0, 1'b1, 32'h4, 32'hA5A5A5A5);
        access(0, 1'b0, 32'h4, 32'h0, 32'h4, 32'h0, 1'b0, lat, err, rd, sb);
        m_apply(0, 1'b0, 32'h4, 32'h0);
        n_checks++;
        if (rd !== 32'hA5A5A5A5) begin
            n_errs++;
            $display("FAIL capture_word1 got=%h exp=a5a5a5a5", rd);
        end
        access(0, 1'b0, 32'h8, 32'h0, 32'h8, 32'h0, 1'b0, lat, err, rd, sb);
        m_apply(0, 1'b0, 32'h8, 32'h0);
        n_checks++;
        if (rd !== m_rd[0]) begin
            n_errs++;
            $display("FAIL capture_word2 got=%h exp=%h", rd, m_rd[0]);
        end
    endtask

    task automatic test_reset_mid_wait(input int rst_cycle);
        int seen, lat, sb; logic err; logic [31:0] rd;
        seen = 0;
        drive(0, 1'b1, 1'b1, 32'h0, 32'h1234);
        repeat (rst_cycle) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        m_clear();
        repeat (4) begin
            @(negedge clk);
            if (ready_a !== 1'b0) seen++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (seen !== 0) begin
            n_errs++;
            $display("FAIL rst_c%0d_ready got=%0d pulses exp=0", rst_cycle, seen);
        end
        access(0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, lat, err, rd, sb);
        m_apply(0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (rd !== 32'd0 || lat !== 3) begin
            n_errs++;
            $display("FAIL rst_c%0d_load got d=%h lat=%0d exp 0/3", rst_cycle, rd, lat);
        end
    endtask

    task automatic test_cs_drop();
        int lat, sb; logic err; logic [31:0] rd;
        lat = -1;
        drive(0, 1'b1, 1'b1, 32'h8, 32'h99);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, $urandom, $urandom);
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (ready_a === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        m_apply(0, 1'b1, 32'h8, 32'h99);
        n_checks++;
        if (lat !== 3) begin
            n_errs++;
            $display("FAIL cs_drop_ready got lat=%0d exp=3", lat);
        end
        access(0, 1'b0, 32'h8, 32'h0, 32'h8, 32'h0, 1'b0, lat, err, rd, sb);
        m_apply(0, 1'b0, 32'h8, 32'h0);
        n_checks++;
        if (rd !== 32'h99) begin
            n_errs++;
            $display("FAIL cs_drop_data got=%h exp=00000099", rd);
        end
    endtask

    task automatic test_latency0();
        int lat, sb; logic err; logic [31:0] rd;
        access(1, 1'b1, 32'h4, 32'h7, 32'h4, 32'h7, 1'b0, lat, err, rd, sb);
        m_apply(1, 1'b1, 32'h4, 32'h7);
        n_checks++;
        if (lat !== 1 || sb !== 0) begin
            n_errs++;
            $display("FAIL lat0_store got lat=%0d stall_bad=%0d exp 1/0", lat, sb);
        end
        access(1, 1'b0, 32'h4, 32'h0, 32'h4, 32'h0, 1'b0, lat, err, rd, sb);
        m_apply(1, 1'b0, 32'h4, 32'h0);
        n_checks++;
        if (lat !== 1 || sb !== 0 || rd !== 32'h7) begin
            n_errs++;
            $display("FAIL lat0_load got lat=%0d sb=%0d d=%h exp 1/0/7", lat, sb, rd);
        end
    endtask

    task automatic test_random(input int sel, input int n);
        int lat, sb; logic err, we, keep, e_err; logic [31:0] a, d, rd;
        for (int i = 0; i < n; i++) begin
            we   = 1'($urandom_range(0, 1));
            keep = 1'($urandom_range(0, 1));
            a    = rand_addr();
            d    = $urandom;
            e_err = m_err(a);
            access(sel, we, a, d, $urandom, $urandom, keep, lat, err, rd, sb);
            m_apply(sel, we, a, d);
            n_checks++;
            if (lat !== exp_lat(sel) || sb !== 0 || err !== e_err
                || rd !== m_rd[sel]) begin
                n_errs++;
                $display("FAIL rand%0d_%0d we=%b a=%h got lat=%0d sb=%0d err=%b d=%h exp lat=%0d err=%b d=%h",
                         sel, i, we, a, lat, sb, err, rd, exp_lat(sel), e_err, m_rd[sel]);
            end
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_reset_load();
        test_store_load();
        test_errors();
        test_capture();
        test_reset_mid_wait(1);
        test_reset_mid_wait(2);
        test_cs_drop();
        test_latency0();
        test_random(0, 60);
        test_random(1, 60);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
